// File: rtl/wash_sequencer.sv
// Wash-cycle sequencer: charges the balance on start, counts down WASH/RINSE/SPIN
// in whole seconds, supports pause/resume and abort, and raises a finish alarm.
module wash_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned RINSE_S       = 10,
  parameter int unsigned SPIN_S        = 5,
  parameter int unsigned ALARM_TICKS   = 250000000,
  parameter int unsigned PRICE0        = 5,
  parameter int unsigned PRICE1        = 3,
  parameter int unsigned PRICE2        = 4,
  parameter int unsigned PRICE3        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_bal,
  input  logic signed [10:0] bal_in,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [6:0]         wash_s,
  input  logic               pause,
  input  logic               abort,
  output logic signed [10:0] bal,
  output logic               busy,
  output logic               paused,
  output logic [2:0]         phase_light,
  output logic [8:0]         rem_s,
  output logic [3:0]         d0,
  output logic [3:0]         d1,
  output logic [3:0]         d2,
  output logic               reject,
  output logic               alarm
);

  localparam int unsigned BW = 11;
  localparam int unsigned PW = 7;
  localparam int unsigned RW = 9;
  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_PAUSE, S_DONE} state_t;

  state_t               state_q, state_d, ret_q, ret_d;
  logic [1:0]           mode_q, mode_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [AW-1:0]        acnt_q, acnt_d;
  logic signed [BW-1:0] bal_d;
  logic [RW-1:0]        rem_d;
  logic                 busy_d, paused_d, reject_d, alarm_d;
  logic [2:0]           light_d;
  logic                 sec_tick;

  logic [PW-1:0]        wash_eff, wash_dur;
  logic [RW-1:0]        total;
  logic signed [BW-1:0] price;
  logic                 refuse;

  function automatic logic [PW-1:0] rinse_dur(input logic [1:0] m);
    return (m == 2'd0 || m == 2'd2) ? PW'(RINSE_S) : '0;
  endfunction

  function automatic logic [PW-1:0] spin_dur(input logic [1:0] m);
    return (m != 2'd1) ? PW'(SPIN_S) : '0;
  endfunction

  function automatic logic [2:0] light_of(input state_t s);
    case (s)
      S_WASH:  return 3'b001;
      S_RINSE: return 3'b010;
      S_SPIN:  return 3'b100;
      S_DONE:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Start evaluation: clamped wash time, cycle total, price and refusal
  always_comb begin
    wash_eff = (wash_s > 7'd99) ? 7'd99 : wash_s;
    wash_dur = (mode <= 2'd1) ? wash_eff : '0;
    total    = RW'(wash_dur) + RW'(rinse_dur(mode)) + RW'(spin_dur(mode));
    case (mode)
      2'd0:    price = BW'(PRICE0);
      2'd1:    price = BW'(PRICE1);
      2'd2:    price = BW'(PRICE2);
      default: price = BW'(PRICE3);
    endcase
    refuse = (bal < price) || ((mode <= 2'd1) && (wash_s == 7'd0)) || (total == '0);
  end

  // BCD digits of the remaining time for the display scanner
  always_comb begin
    d0 = 4'(rem_s % 9'd10);
    d1 = 4'((rem_s / 9'd10) % 9'd10);
    d2 = 4'(rem_s / 9'd100);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    mode_d   = mode_q;
    tick_d   = tick_q;
    pcnt_d   = pcnt_q;
    acnt_d   = acnt_q;
    bal_d    = bal;
    rem_d    = rem_s;
    reject_d = 1'b0;
    sec_tick = (tick_q == TW'(TICKS_PER_SEC - 1));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (refuse) begin
            reject_d = 1'b1;
          end else begin
            bal_d  = bal - price;
            mode_d = mode;
            rem_d  = total;
            tick_d = '0;
            if (wash_dur != '0) begin
              state_d = S_WASH;
              pcnt_d  = wash_dur;
            end else if (rinse_dur(mode) != '0) begin
              state_d = S_RINSE;
              pcnt_d  = rinse_dur(mode);
            end else begin
              state_d = S_SPIN;
              pcnt_d  = spin_dur(mode);
            end
          end
        end else if (load_bal) begin
          bal_d = bal_in;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
          tick_d  = '0;
          pcnt_d  = '0;
        end else begin
          tick_d = sec_tick ? '0 : tick_q + TW'(1);
          if (sec_tick) begin
            rem_d = rem_s - RW'(1);
            if (pcnt_q == PW'(1)) begin
              if (state_q == S_WASH && rinse_dur(mode_q) != '0) begin
                state_d = S_RINSE;
                pcnt_d  = rinse_dur(mode_q);
              end else if (state_q != S_SPIN && spin_dur(mode_q) != '0) begin
                state_d = S_SPIN;
                pcnt_d  = spin_dur(mode_q);
              end else begin
                state_d = S_DONE;
                pcnt_d  = '0;
              end
            end else begin
              pcnt_d = pcnt_q - PW'(1);
            end
          end
          // The tick lands first; a pause then parks whichever phase is current
          if (pause && state_d != S_DONE) begin
            ret_d   = state_d;
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
          tick_d  = '0;
          pcnt_d  = '0;
        end else if (pause) begin
          state_d = ret_q;
        end
      end
      S_DONE: begin
        if (acnt_q == AW'(ALARM_TICKS - 1)) begin
          state_d = S_IDLE;
        end else begin
          acnt_d = acnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      acnt_d = '0;
      tick_d = '0;
    end

    busy_d   = (state_d == S_WASH) || (state_d == S_RINSE) ||
               (state_d == S_SPIN) || (state_d == S_PAUSE);
    paused_d = (state_d == S_PAUSE);
    alarm_d  = (state_d == S_DONE);
    light_d  = light_of((state_d == S_PAUSE) ? ret_d : state_d);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      mode_q      <= '0;
      tick_q      <= '0;
      pcnt_q      <= '0;
      acnt_q      <= '0;
      bal         <= '0;
      rem_s       <= '0;
      busy        <= 1'b0;
      paused      <= 1'b0;
      phase_light <= '0;
      reject      <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      mode_q      <= mode_d;
      tick_q      <= tick_d;
      pcnt_q      <= pcnt_d;
      acnt_q      <= acnt_d;
      bal         <= bal_d;
      rem_s       <= rem_d;
      busy        <= busy_d;
      paused      <= paused_d;
      phase_light <= light_d;
      reject      <= reject_d;
      alarm       <= alarm_d;
    end
  end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Sequences one wash cycle after the entry stage has captured balance, mode and wash time.
- On an accepted start it charges the balance once, then runs the phases WASH -> RINSE -> SPIN as selected by mode, with a 1-second countdown.
- Supports pause/resume and abort, and raises a finish alarm.
- Drives phase lights and BCD remaining-time digits for the 7-segment scanner.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per 1 s countdown tick
- RINSE_S, 10, rinse phase duration in seconds
- SPIN_S, 5, spin phase duration in seconds
- ALARM_TICKS, 250000000, clk cycles the alarm stays high in DONE
- PRICE0, 5, PRICE1, 3, PRICE2, 4, PRICE3, 2: cost of modes 0..3

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load_bal  in  1  one-cycle pulse; bal <= bal_in
- bal_in  in  11  signed balance from entry stage (0..999)
- start  in  1  one-cycle start request
- mode  in  2  0 = wash+rinse+spin, 1 = wash only, 2 = rinse+spin, 3 = spin only
- wash_s  in  7  wash duration in seconds, 0..99; values >99 are treated as 99
- pause  in  1  one-cycle pulse; toggles pause/resume
- abort  in  1  one-cycle pulse; cancels the cycle
- bal  out  11  signed current balance
- busy  out  1  high in WASH/RINSE/SPIN/PAUSE
- paused  out  1  high in PAUSE
- phase_light  out  3  one-hot lights: [0] WASH, [1] RINSE, [2] SPIN; all ones in DONE
- rem_s  out  9  total remaining seconds of the cycle
- d0, d1, d2  out  4 each  BCD ones/tens/hundreds of rem_s
- reject  out  1  one-cycle pulse when start is refused
- alarm  out  1  finish alarm

Behaviour:
- Reset (async, rst=0): state IDLE; bal=0, rem_s=0, tick counter=0, phase counter=0, alarm=0, reject=0, busy=0, paused=0, phase_light=0.
- States: IDLE, WASH, RINSE, SPIN, PAUSE, DONE. All outputs are registered except d0..d2, which decode rem_s combinationally.
- load_bal: accepted only in IDLE; ignored in every other state.
- Phase durations:
  - WASH = wash_s in modes 0/1, else 0.
  - RINSE = RINSE_S in modes 0/2, else 0.
  - SPIN = SPIN_S in modes 0/2/3, else 0.
  - A phase with duration 0 is skipped and never entered.
- Start, IDLE only:
  - Refused if bal < PRICE[mode], or if mode is 0/1 and wash_s == 0. Refusal: reject=1 for one cycle; bal and state unchanged.
  - Accepted: on the next edge bal <= bal - PRICE[mode]; state <= first non-zero phase; phase counter <= that phase's duration; rem_s <= sum of all durations; tick counter <= 0.
  - mode and wash_s are sampled only at acceptance. Later changes have no effect.
- start in any non-IDLE state is ignored, with no reject.
- Running (WASH/RINSE/SPIN):
  - Tick counter increments every clk and wraps at TICKS_PER_SEC-1. The wrap cycle is a second tick.
  - On a second tick: rem_s-1. If phase counter == 1, advance on that same edge to the next non-zero phase (loading its duration), or to DONE if none remains. Otherwise phase counter-1.
- Pause:
  - In a running state: go to PAUSE, remembering the phase. Tick counter and phase counter are frozen, not cleared.
  - In PAUSE: resume the remembered phase with the counters intact. Resume does not itself produce a tick.
- Abort:
  - In running or PAUSE: state <= IDLE, rem_s <= 0, counters cleared. No refund.
  - Abort and pause in the same cycle: abort wins.
  - Abort in IDLE or DONE: ignored.
- Second tick coinciding with pause: the tick is applied first, then the block pauses. If the tick finished the last phase, it goes to DONE and the pause is ignored.
- DONE:
  - alarm=1 for exactly ALARM_TICKS cycles, then IDLE with alarm=0.
  - start, pause and abort are ignored in DONE.
- Balance never goes negative, because start is refused when insufficient.
- Reset mid-cycle: immediate IDLE; bal cleared.

Test Plan:
- Use TICKS_PER_SEC=4, RINSE_S=2, SPIN_S=1, ALARM_TICKS=6 for all scenarios.
- Funds refusal: load bal_in=4, mode 0, start -> reject pulses once; bal=4; state IDLE.
- Full cycle: bal=20, mode 0, wash_s=3, start:
  - bal=15, rem_s=6, phase_light=001.
  - After 12 cycles phase_light=010; after 20 cycles 100; after 24 cycles DONE with phase_light=111.
  - alarm high for 6 cycles, then IDLE with rem_s=0.
- Skipped phases: mode 3, bal=2, start -> bal=0; enters SPIN directly with rem_s=1; DONE after 4 cycles.
- Pause/resume: mode 1, wash_s=2; pause after 5 cycles (rem_s=1); hold 50 cycles -> rem_s stays 1, paused=1; pause again -> DONE after 3 more cycles.
- Abort precedence: during RINSE assert pause and abort in the same cycle -> IDLE, busy=0, rem_s=0; bal not refunded.
- Zero wash / busy start: mode 0 with wash_s=0 -> reject. A start pulse during WASH -> ignored; no bal change, no reject.
